// File: rtl/cdc_event_monitor.sv
// cdc_event_monitor: rising-edge detector, event counter, edge-to-edge
// period measurement and lock/loss-of-lock tracking for a signal already
// synchronised into the clk_2 domain.
// Optional feature: define EVT_PERIOD_CHECK_EN to add the PER_MIN/PER_MAX
// window check that drives a sticky per_err. Without it per_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no edge seen since reset/clear, no reference for a period
// ST_LOCKED | edges arriving within TIMEOUT cycles, periods are valid
// ST_LOST   | TIMEOUT cycles passed without an edge, next interval invalid
module cdc_event_monitor #(
    parameter int CNT_W   = 16,
    parameter int PER_W   = 8,
    parameter int TIMEOUT = 64
`ifdef EVT_PERIOD_CHECK_EN
    ,
    parameter int PER_MIN = 8,
    parameter int PER_MAX = 12
`endif
) (
    input  logic             clk_2,
    input  logic             kill,
    input  logic             sig_in,
    input  logic             clr,
    output logic             evt_pulse,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [PER_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout,
    output logic             per_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_LOST   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sig_d;
    logic             r_evt_pulse;
    logic             r_period_vld;
    logic [CNT_W-1:0] r_evt_cnt;
    logic [PER_W-1:0] r_gap_cnt;
    logic [PER_W-1:0] r_period;
    logic             w_edge;
    logic             w_gap_sat;
    logic             w_cnt_sat;
    logic             w_gap_to;

    assign w_edge    = sig_in & ~r_sig_d;
    assign w_gap_sat = (r_gap_cnt == {PER_W{1'b1}});
    assign w_cnt_sat = (r_evt_cnt == {CNT_W{1'b1}});
    assign w_gap_to  = (r_gap_cnt == PER_W'(TIMEOUT));

    // Delayed copy of sig_in for edge detection; clr does not touch it so a
    // level that stays high across a clear is not re-detected as an edge.
    always_ff @(posedge clk_2) begin
        if (kill) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= sig_in;
        end
    end

    // State register.
    always_ff @(posedge clk_2) begin
        if (kill) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an edge arriving as the gap hits TIMEOUT keeps lock.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_edge) w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (!w_edge && w_gap_to) w_state_nxt = ST_LOST;
                ST_LOST:   if (w_edge) w_state_nxt = ST_LOCKED;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Event counter, gap counter, period capture and strobes.
    always_ff @(posedge clk_2) begin
        if (kill) begin
            r_evt_pulse  <= 1'b0;
            r_period_vld <= 1'b0;
            r_evt_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_period     <= '0;
        end else if (clr) begin
            r_evt_pulse  <= 1'b0;
            r_period_vld <= 1'b0;
            r_evt_cnt    <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_evt_pulse  <= w_edge;
            r_period_vld <= w_edge && (r_state == ST_LOCKED);
            if (w_edge) begin
                r_gap_cnt <= PER_W'(1);
                if (!w_cnt_sat) begin
                    r_evt_cnt <= r_evt_cnt + CNT_W'(1);
                end
                if (r_state == ST_LOCKED) begin
                    r_period <= r_gap_cnt;
                end
            end else if (!w_gap_sat) begin
                r_gap_cnt <= r_gap_cnt + PER_W'(1);
            end
        end
    end

`ifdef EVT_PERIOD_CHECK_EN
    logic r_per_err;

    // Sticky flag set alongside any period strobe outside [PER_MIN, PER_MAX].
    always_ff @(posedge clk_2) begin
        if (kill || clr) begin
            r_per_err <= 1'b0;
        end else if (w_edge && (r_state == ST_LOCKED) &&
                     ((r_gap_cnt < PER_W'(PER_MIN)) || (r_gap_cnt > PER_W'(PER_MAX)))) begin
            r_per_err <= 1'b1;
        end
    end

    assign per_err = r_per_err;
`else
    assign per_err = 1'b0;
`endif

    assign evt_pulse  = r_evt_pulse;
    assign period_vld = r_period_vld;
    assign evt_cnt    = r_evt_cnt;
    assign period     = r_period;
    assign locked     = (r_state == ST_LOCKED);
    assign timeout    = (r_state == ST_LOST);

endmodule

// File: tb/tb_cdc_event_monitor.sv
// Directed bench for cdc_event_monitor: default-parameter instance plus a
// CNT_W=4 instance sharing the same stimulus for the saturation case.
module tb_cdc_event_monitor;

`ifdef EVT_PERIOD_CHECK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    logic        clk_2 = 1'b0;
    logic        kill;
    logic        sig_in;
    logic        clr;
    logic        evt_pulse;
    logic [15:0] evt_cnt;
    logic [7:0]  period;
    logic        period_vld;
    logic        locked;
    logic        timeout;
    logic        per_err;

    logic        evt_pulse4;
    logic [3:0]  evt_cnt4;
    logic [7:0]  period4;
    logic        period_vld4;
    logic        locked4;
    logic        timeout4;
    logic        per_err4;

    int errors = 0;
    int checks = 0;
    int vld_cnt;
    int pulse_cnt;

    cdc_event_monitor #(.CNT_W(16), .PER_W(8), .TIMEOUT(64)) dut (
        .clk_2(clk_2), .kill(kill), .sig_in(sig_in), .clr(clr),
        .evt_pulse(evt_pulse), .evt_cnt(evt_cnt), .period(period),
        .period_vld(period_vld), .locked(locked), .timeout(timeout),
        .per_err(per_err)
    );

    cdc_event_monitor #(.CNT_W(4), .PER_W(8), .TIMEOUT(64)) dut4 (
        .clk_2(clk_2), .kill(kill), .sig_in(sig_in), .clr(clr),
        .evt_pulse(evt_pulse4), .evt_cnt(evt_cnt4), .period(period4),
        .period_vld(period_vld4), .locked(locked4), .timeout(timeout4),
        .per_err(per_err4)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        kill = 1'b1; clr = 1'b0; sig_in = 1'b0;
        repeat (3) tick();
        chk("rst_evt_cnt", 32'(evt_cnt), 0);
        chk("rst_period", 32'(period), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_evt_pulse", 32'(evt_pulse), 0);
        chk("rst_period_vld", 32'(period_vld), 0);
        chk("rst_per_err", 32'(per_err), 0);
        kill = 1'b0;
        tick();
        chk("idle_locked", 32'(locked), 0);

        // Five pulses every 10 cycles
        vld_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            sig_in = 1'b1;
            tick();
            chk("p10_evt_pulse", 32'(evt_pulse), 1);
            chk("p10_evt_cnt", 32'(evt_cnt), 32'(i + 1));
            chk("p10_locked", 32'(locked), 1);
            chk("p10_vld", 32'(period_vld), (i > 0) ? 1 : 0);
            if (i > 0) chk("p10_period", 32'(period), 10);
            vld_cnt += int'(period_vld);
            sig_in = 1'b0;
            repeat (9) begin
                tick();
                vld_cnt += int'(period_vld);
            end
        end
        chk("p10_vld_count", 32'(vld_cnt), 4);
        chk("p10_evt_cnt_final", 32'(evt_cnt), 5);

        // Loss of lock: 54 more idle cycles brings gap to 64 (still locked)
        repeat (54) tick();
        chk("to_locked_at_63", 32'(locked), 1);
        chk("to_timeout_at_63", 32'(timeout), 0);
        tick();
        chk("to_locked_at_64", 32'(locked), 0);
        chk("to_timeout_at_64", 32'(timeout), 1);
        sig_in = 1'b1;
        tick();
        chk("relock_locked", 32'(locked), 1);
        chk("relock_timeout", 32'(timeout), 0);
        chk("relock_pulse", 32'(evt_pulse), 1);
        chk("relock_vld", 32'(period_vld), 0);
        chk("relock_period", 32'(period), 10);
        chk("relock_evt_cnt", 32'(evt_cnt), 6);
        sig_in = 1'b0;

        // Edge exactly as the gap reaches TIMEOUT keeps lock, period=64
        repeat (63) tick();
        sig_in = 1'b1;
        tick();
        chk("edge_to_locked", 32'(locked), 1);
        chk("edge_to_timeout", 32'(timeout), 0);
        chk("edge_to_vld", 32'(period_vld), 1);
        chk("edge_to_period", 32'(period), 64);
        chk("edge_to_evt_cnt", 32'(evt_cnt), 7);
        sig_in = 1'b0;

        // Clear, three pulses spaced 12, then clr collides with an edge
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_evt_cnt", 32'(evt_cnt), 0);
        chk("clr_locked", 32'(locked), 0);
        chk("clr_period_kept", 32'(period), 64);
        for (int i = 0; i < 3; i++) begin
            sig_in = 1'b1;
            tick();
            sig_in = 1'b0;
            repeat (11) tick();
        end
        chk("p12_period", 32'(period), 12);
        chk("p12_evt_cnt", 32'(evt_cnt), 3);
        sig_in = 1'b1; clr = 1'b1;
        tick();
        chk("clr_edge_pulse", 32'(evt_pulse), 0);
        chk("clr_edge_vld", 32'(period_vld), 0);
        chk("clr_edge_evt_cnt", 32'(evt_cnt), 0);
        chk("clr_edge_locked", 32'(locked), 0);
        chk("clr_edge_timeout", 32'(timeout), 0);
        chk("clr_edge_period", 32'(period), 12);
        clr = 1'b0;
        tick();
        chk("clr_level_no_pulse", 32'(evt_pulse), 0);
        chk("clr_level_evt_cnt", 32'(evt_cnt), 0);
        sig_in = 1'b0;
        tick();

        // Level held high for 30 cycles gives one pulse
        pulse_cnt = 0;
        sig_in = 1'b1;
        repeat (30) begin
            tick();
            pulse_cnt += int'(evt_pulse);
        end
        sig_in = 1'b0;
        tick();
        pulse_cnt += int'(evt_pulse);
        chk("level_pulse_count", 32'(pulse_cnt), 1);
        chk("level_evt_cnt", 32'(evt_cnt), 1);

        // Saturation: 17 pulses into a 4-bit counter
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat_clr_cnt4", 32'(evt_cnt4), 0);
        repeat (17) begin
            sig_in = 1'b1;
            tick();
            sig_in = 1'b0;
            tick();
        end
        chk("sat_evt_cnt16", 32'(evt_cnt), 17);
        chk("sat_evt_cnt4", 32'(evt_cnt4), 15);

        // kill beats clr; sig_in already high at release is an edge
        kill = 1'b1; clr = 1'b1; sig_in = 1'b1;
        tick();
        chk("kill_evt_cnt", 32'(evt_cnt), 0);
        chk("kill_period", 32'(period), 0);
        chk("kill_locked", 32'(locked), 0);
        chk("kill_pulse", 32'(evt_pulse), 0);
        chk("kill_per_err", 32'(per_err), 0);
        kill = 1'b0; clr = 1'b0;
        tick();
        chk("post_kill_pulse", 32'(evt_pulse), 1);
        chk("post_kill_evt_cnt", 32'(evt_cnt), 1);
        chk("post_kill_locked", 32'(locked), 1);
        chk("post_kill_vld", 32'(period_vld), 0);
        sig_in = 1'b0;

        // Period window: spacing 10, 10, 14
        clr = 1'b1;
        tick();
        clr = 1'b0;
        sig_in = 1'b1;
        tick();
        sig_in = 1'b0;
        repeat (9) tick();
        for (int i = 0; i < 2; i++) begin
            sig_in = 1'b1;
            tick();
            chk("win_vld_ok", 32'(period_vld), 1);
            chk("win_period_ok", 32'(period), 10);
            chk("win_per_err_ok", 32'(per_err), 0);
            sig_in = 1'b0;
            repeat ((i == 0) ? 9 : 13) tick();
        end
        sig_in = 1'b1;
        tick();
        chk("win_vld_bad", 32'(period_vld), 1);
        chk("win_period_bad", 32'(period), 14);
        chk("win_per_err_rise", 32'(per_err), 32'(CHK_EN));
        sig_in = 1'b0;
        repeat (5) tick();
        chk("win_per_err_sticky", 32'(per_err), 32'(CHK_EN));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("win_per_err_clr", 32'(per_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdc_event_monitor.md
CDC_EVENT_MONITOR -- requirements
Module: cdc_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: event counter width.
REQ-002 SHALL have parameter PER_W, default 8: period measurement width.
REQ-003 SHALL have parameter TIMEOUT, default 64: clk_2 cycles without an edge before loss of lock; legal range 2..2^PER_W-1.
REQ-004 SHALL have port clk_2, input, 1: single clock, all logic on its rising edge.
REQ-005 SHALL have port kill, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port sig_in, input, 1: level already synchronised into the clk_2 domain by a 2-FF synchroniser.
REQ-007 SHALL have port clr, input, 1: synchronous soft clear of counters and state.
REQ-008 SHALL have port evt_pulse, output, 1: one-cycle strobe per sig_in rising edge.
REQ-009 SHALL have port evt_cnt, output, CNT_W: count of detected edges.
REQ-010 SHALL have port period, output, PER_W: last measured edge-to-edge interval in clk_2 cycles.
REQ-011 SHALL have port period_vld, output, 1: one-cycle strobe when period updates.
REQ-012 SHALL have port locked, output, 1: high in state LOCKED.
REQ-013 SHALL have port timeout, output, 1: high in state LOST.

Function
REQ-014 SHALL register sig_in into sig_d every cycle, including cycles with clr high; edge = sig_in & ~sig_d.
REQ-015 SHALL drive evt_pulse registered from edge: high exactly one cycle, the cycle after the first clk_2 edge sampling sig_in=1. A level held high gives one pulse only.
REQ-016 SHALL increment evt_cnt on the same clock edge that sets evt_pulse; evt_cnt saturates at all-ones and never wraps.
REQ-017 SHALL keep gap counter gap_cnt: reset to 1 on edge, else increment; saturates at 2^PER_W-1.
REQ-018 SHALL, on an edge in state LOCKED, load period <= gap_cnt and pulse period_vld, both aligned with evt_pulse.
REQ-019 SHALL implement FSM IDLE / LOCKED / LOST: IDLE->LOCKED on first edge, with no period_vld; LOCKED->LOST when gap_cnt reaches TIMEOUT with no edge; LOST->LOCKED on edge, with no period_vld because the interval is invalid; any state ->IDLE on clr.
REQ-020 SHALL give clr priority over a same-cycle edge: edge dropped, evt_cnt=0, gap_cnt=0, period unchanged, no strobes.
REQ-021 SHALL treat an edge in the same cycle gap_cnt reaches TIMEOUT as an edge: stay LOCKED, period=TIMEOUT.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 SHALL, with kill high at a clk_2 edge, set state=IDLE, sig_d=0, evt_cnt=0, gap_cnt=0, period=0, all strobes 0, locked=0, timeout=0, and per_err=0 if present.
REQ-024 SHALL give kill priority over clr and sig_in; kill mid-measurement discards the partial interval.
REQ-025 SHALL detect an edge if sig_in is already high when kill releases, on the first post-reset cycle, because sig_d=0.

Configuration
REQ-026 SHALL, with macro EVT_PERIOD_CHECK_EN defined, add parameters PER_MIN (default 8) and PER_MAX (default 12) and output per_err, 1 bit, sticky-set on any period_vld with period outside [PER_MIN,PER_MAX]; per_err clears only on kill or clr.
REQ-027 SHALL, without EVT_PERIOD_CHECK_EN, keep per_err port present tied to 0 and synthesise no comparison logic.

Verification
REQ-028 SHALL cover this scenario: sig_in 1-cycle pulse every 10 clk_2 cycles, 5 pulses -> evt_cnt=5; locked after pulse 1; 4 period_vld strobes, each period=10.
REQ-029 SHALL cover this scenario: after lock, sig_in held 0 for 64 cycles with TIMEOUT=64 -> timeout=1 and locked=0 exactly when gap_cnt=64; next pulse -> locked=1 with no period_vld.
REQ-030 SHALL cover this scenario: clr asserted in the same cycle as an edge with evt_cnt=3 -> evt_cnt=0, state IDLE, no evt_pulse, period keeps its old value.
REQ-031 SHALL cover this scenario: sig_in held high 30 cycles -> exactly one evt_pulse, evt_cnt +1.
REQ-032 SHALL cover this scenario: with CNT_W=4, 17 pulses -> evt_cnt=15 (saturated).
REQ-033 SHALL cover this scenario: with EVT_PERIOD_CHECK_EN defined, pulses spaced 10,10,14 -> per_err rises with the third period_vld (period=14) and stays 1 until clr.
